uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/uart_rx.sv | 129 ++++++++++++
 tb/tb_uart_rx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  // Receiver frame-tracking states
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  // Divider below this leaves too little room to find the middle of a bit
  localparam int MIN_CLKS_PER_BIT = 4;

  // Payload width of one 8N1 frame
  localparam int DATA_BITS = 8;

  // Whole system clocks per line bit; any fractional part is discarded
  function automatic int clks_per_bit(input int clk_rate, input int baud);
    return clk_rate / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Both stages reset to RESET_VAL so an undriven input before the first edge
// never propagates past the synchronizer.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic areset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to settle
  always_ff @(posedge clk) begin
    if (areset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 1 start bit, 8 data bits LSB first, 1 stop bit.
// Received bytes are presented on a valid/ready stream. A byte that
// completes while the previous one is still waiting is dropped, and a
// stop bit read as low parks the receiver until the line returns high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_RATE  = 50_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       rx,
  input  logic       ready,
  output logic       data_val,
  output logic [7:0] data
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_RATE, BAUD_RATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  // Count at which the start bit is re-checked (middle of the start bit)
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  // Count at which data and stop bits are sampled (one bit period later)
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_bad_rate
    $error("uart_rx: CLK_RATE/BAUD_RATE must be at least 4");
  end

  rx_state_t        state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             rx_s;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .areset(areset),
    .d     (rx),
    .q     (rx_s)
  );

  // Frame FSM with baud timing, bit assembly and the output handshake
  always_ff @(posedge clk) begin
    if (areset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      data     <= '0;
      data_val <= 1'b0;
    end else begin
      if (data_val && ready) begin
        data_val <= 1'b0;
      end

      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (!rx_s) begin
            state <= START;
          end
        end

        START: begin
          if (baud_cnt == CNT_HALF) begin
            baud_cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt        <= '0;
            shreg[bit_cnt]  <= rx_s;
            bit_cnt         <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state <= STOP;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            if (rx_s) begin
              if (!data_val) begin
                data     <= shreg;
                data_val <= 1'b1;
              end
              state <= IDLE;
            end else begin
              state <= BREAK;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        BREAK: begin
          baud_cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: begin
          baud_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 10 clocks per bit: table of frames plus hand-written
// glitch, framing-error, overrun and mid-frame reset sequences. Expected
// bytes go into a queue as frames are driven and are matched on handshakes.
module tb_uart_rx;

  localparam int CLKS_PER_BIT = 10;

  typedef struct {
    logic [7:0] value;
    logic       stop_bit;
    logic       expect_out;
  } vec_t;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic       data_val;
  logic [7:0] data;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;
  logic       prev_handshake = 1'b0;
  vec_t       vecs[9];

  uart_rx #(
    .CLK_RATE (10),
    .BAUD_RATE(1)
  ) dut (
    .clk     (clk),
    .areset  (areset),
    .rx      (rx),
    .ready   (ready),
    .data_val(data_val),
    .data    (data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic driveBit(input logic b);
    rx = b;
    waitCycles(CLKS_PER_BIT);
  endtask

  task automatic applyStimulus(input logic [7:0] value, input logic stop_bit);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) begin
      driveBit(value[i]);
    end
    driveBit(stop_bit);
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      waitCycles(1);
      n++;
    end
    checkOutput(name, exp_q.size(), 0);
  endtask

  // Scoreboard: every handshake must match the oldest expected byte, and
  // data_val must drop on the edge after a handshake
  always @(negedge clk) begin
    if (areset) begin
      prev_handshake <= 1'b0;
    end else begin
      if (prev_handshake) begin
        checkOutput("valid_drop_after_handshake", data_val, 0);
      end
      if (data_val && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got 0x%0h, expected no byte", data);
        end else begin
          exp_byte = exp_q.pop_front();
          checkOutput("rx_byte", data, exp_byte);
        end
      end
      prev_handshake <= data_val && ready;
    end
  end

  // Watchdog so a stuck run still ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{8'h68, 1'b1, 1'b1};
    vecs[1] = '{8'h65, 1'b1, 1'b1};
    vecs[2] = '{8'h6C, 1'b1, 1'b1};
    vecs[3] = '{8'h6C, 1'b1, 1'b1};
    vecs[4] = '{8'h6F, 1'b1, 1'b1};
    vecs[5] = '{8'h0A, 1'b1, 1'b1};
    vecs[6] = '{8'h55, 1'b1, 1'b1};
    vecs[7] = '{8'h00, 1'b1, 1'b1};
    vecs[8] = '{8'hFF, 1'b1, 1'b1};

    areset = 1'b1;
    rx     = 1'b1;
    ready  = 1'b1;
    waitCycles(3);
    @(negedge clk);
    checkOutput("reset_data_val", data_val, 0);
    checkOutput("reset_data", data, 8'h00);
    @(posedge clk);
    #1;
    areset = 1'b0;
    waitCycles(CLKS_PER_BIT);

    // Back-to-back frames, no idle gap between stop and next start
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].expect_out) begin
        exp_q.push_back(vecs[i].value);
      end
      applyStimulus(vecs[i].value, vecs[i].stop_bit);
    end
    waitDrain("drain_table", 40);

    // Short low glitch on an idle line must be ignored
    rx = 1'b0;
    waitCycles(3);
    rx = 1'b1;
    waitCycles(2 * CLKS_PER_BIT);
    exp_q.push_back(8'hA5);
    applyStimulus(8'hA5, 1'b1);
    waitDrain("drain_after_glitch", 40);

    // Framing error, line held low, then a good frame
    applyStimulus(8'h3C, 1'b0);
    rx = 1'b0;
    waitCycles(2 * CLKS_PER_BIT);
    rx = 1'b1;
    waitCycles(CLKS_PER_BIT);
    exp_q.push_back(8'h81);
    applyStimulus(8'h81, 1'b1);
    waitDrain("drain_after_framing", 40);

    // Overrun: consumer stalled, second byte must be dropped
    ready = 1'b0;
    exp_q.push_back(8'h12);
    applyStimulus(8'h12, 1'b1);
    @(negedge clk);
    checkOutput("stall_valid_first", data_val, 1);
    checkOutput("stall_data_first", data, 8'h12);
    @(posedge clk);
    #1;
    applyStimulus(8'h34, 1'b1);
    waitCycles(5);
    @(negedge clk);
    checkOutput("overrun_valid_held", data_val, 1);
    checkOutput("overrun_data_held", data, 8'h12);
    checkOutput("overrun_not_consumed", exp_q.size(), 1);
    @(posedge clk);
    #1;
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    @(negedge clk);
    checkOutput("valid_after_release", data_val, 0);
    checkOutput("overrun_consumed", exp_q.size(), 0);
    waitCycles(2 * CLKS_PER_BIT);
    @(negedge clk);
    checkOutput("overrun_byte_dropped", data_val, 0);
    @(posedge clk);
    #1;
    ready = 1'b1;
    waitCycles(CLKS_PER_BIT);

    // Reset during bit 4 of frame 0xF5, then a fresh frame
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b0);
    rx = 1'b1;
    waitCycles(4);
    areset = 1'b1;
    waitCycles(2);
    @(negedge clk);
    checkOutput("midframe_reset_valid", data_val, 0);
    checkOutput("midframe_reset_data", data, 8'h00);
    @(posedge clk);
    #1;
    areset = 1'b0;
    waitCycles(5 * CLKS_PER_BIT);
    @(negedge clk);
    checkOutput("aborted_frame_silent", data_val, 0);
    @(posedge clk);
    #1;
    exp_q.push_back(8'hF0);
    applyStimulus(8'hF0, 1'b1);
    waitDrain("drain_after_reset", 40);

    waitCycles(CLKS_PER_BIT);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
